// File: rtl/mult_accum_if.sv
// Handshake bundle between the product source / result consumer and mult_accum.
// The master side drives products and acknowledges results; the slave side is the accumulator.
interface mult_accum_if #(
    parameter int unsigned P_WIDTH   = 32,
    parameter int unsigned ACC_WIDTH = 40,
    parameter int unsigned LEN_WIDTH = 8
);
    logic                 start;
    logic [LEN_WIDTH-1:0] len;
    logic [P_WIDTH-1:0]   p_in;
    logic                 p_valid;
    logic                 busy;
    logic [ACC_WIDTH-1:0] sum_out;
    logic                 sum_valid;
    logic                 sum_ready;
    logic                 overflow;

    modport master (
        output start, len, p_in, p_valid, sum_ready,
        input  busy, sum_out, sum_valid, overflow
    );

    modport slave (
        input  start, len, p_in, p_valid, sum_ready,
        output busy, sum_out, sum_valid, overflow
    );
endinterface

// File: rtl/mult_accum.sv
// Dot-product back end: sums a programmed number of unsigned products with
// saturation and presents the result over a valid/ready handshake.
module mult_accum #(
    parameter int unsigned P_WIDTH   = 32,
    parameter int unsigned ACC_WIDTH = 40,
    parameter int unsigned LEN_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    mult_accum_if.slave bus
);
    localparam int unsigned ACC_EXT = ACC_WIDTH + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]           state_q,     state_d;
    logic [LEN_WIDTH-1:0] len_q,       len_d;
    logic [LEN_WIDTH-1:0] count_q,     count_d;
    logic [ACC_WIDTH-1:0] acc_q,       acc_d;
    logic [ACC_WIDTH-1:0] sum_q,       sum_d;
    logic                 sum_valid_q, sum_valid_d;
    logic                 busy_q,      busy_d;
    logic                 overflow_q,  overflow_d;

    logic [ACC_WIDTH:0]   add_ext;
    logic [ACC_WIDTH-1:0] add_sat;
    logic [LEN_WIDTH-1:0] count_inc;

    // Saturating add: a carry out pins the accumulator at all ones; an
    // already-saturated accumulator carries on any nonzero product.
    always_comb begin
        add_ext   = {1'b0, acc_q} + ACC_EXT'(bus.p_in);
        add_sat   = add_ext[ACC_WIDTH] ? '1 : add_ext[ACC_WIDTH-1:0];
        count_inc = count_q + LEN_WIDTH'(1);
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        count_d     = count_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        sum_valid_d = sum_valid_q;
        busy_d      = busy_q;
        overflow_d  = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    busy_d     = 1'b1;
                    overflow_d = 1'b0;
                    if (bus.len != '0) begin
                        len_d   = bus.len;
                        acc_d   = '0;
                        count_d = '0;
                        state_d = S_ACCUM;
                    end else begin
                        sum_d       = '0;
                        sum_valid_d = 1'b1;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_ACCUM: begin
                if (bus.p_valid) begin
                    acc_d   = add_sat;
                    count_d = count_inc;
                    if (add_ext[ACC_WIDTH]) begin
                        overflow_d = 1'b1;
                    end
                    if (count_inc == len_q) begin
                        sum_d       = add_sat;
                        sum_valid_d = 1'b1;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.sum_ready) begin
                    sum_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                sum_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.sum_out   = sum_q;
    assign bus.sum_valid = sum_valid_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: doc/mult_accum.md
Name: mult_accum

Overview:
- Downstream stage of the 16x16 unsigned multiplier.
- Consumes the 32-bit product stream P, one product per qualified cycle.
- Accumulates a programmed number of products into a wide sum (dot-product back end).
- Presents the result through a valid/ready handshake.

Parameters:
P_WIDTH, 32, width of incoming product (matches multiplier P).
ACC_WIDTH, 40, accumulator/result width; must be >= P_WIDTH.
LEN_WIDTH, 8, width of the product-count field.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  synchronous active-low reset, sampled on rising clk.
start  input  1  one-cycle pulse; begins a new accumulation.
len  input  LEN_WIDTH  number of products to accumulate; sampled with start.
p_in  input  P_WIDTH  unsigned product from the multiplier.
p_valid  input  1  p_in is qualified this cycle.
busy  output  1  high from the cycle after an accepted start until the result handshake completes.
sum_out  output  ACC_WIDTH  accumulated result, saturated.
sum_valid  output  1  sum_out is valid and held stable.
sum_ready  input  1  consumer accepts sum_out.
overflow  output  1  accumulation saturated; qualified by sum_valid.

Behaviour:
- One clock, clk. Reset is synchronous, active-low on rst_n.
- Reset values: state=IDLE, busy=0, sum_out=0, sum_valid=0, overflow=0, internal count=0, acc=0.
- Reset mid-operation aborts the run; everything returns to reset values on that edge, with no partial result.
- States: IDLE, ACCUM, HOLD.
- IDLE:
  - busy=0; p_valid is ignored.
  - start=1 and len!=0: latch len, clear acc, count and overflow, go to ACCUM.
  - start=1 and len==0: go to HOLD with sum_out=0, overflow=0.
- ACCUM:
  - busy=1; start is ignored.
  - Each cycle with p_valid=1: acc <= acc + zero-extended p_in, count <= count+1.
  - Cycles with p_valid=0 leave acc and count unchanged; gaps are allowed.
  - Saturation: if the add carries out of ACC_WIDTH, acc <= all ones and overflow <= 1 (sticky for the run).
  - Once saturated, later adds keep acc at all ones.
  - When the accepted product brings count to len, load sum_out with the post-add value and go to HOLD.
  - Latency: sum_valid rises on the edge after the final accepted p_valid, i.e. one cycle.
- HOLD:
  - busy=1, sum_valid=1; sum_out and overflow are held stable.
  - p_valid and start are ignored.
  - sum_ready=1: handshake completes on that edge; next cycle sum_valid=0, busy=0, state=IDLE. sum_out keeps its last value.
  - A start in the first IDLE cycle after HOLD is accepted. There is no same-cycle HOLD->ACCUM bypass.
- Width rule: len counts up to 2^LEN_WIDTH-1 = 255 products.
  - Defaults cannot overflow with 16x16 products (255*(2^32-1) < 2^40).
  - Saturation logic is still required for narrower ACC_WIDTH configurations.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset, then start with len=3; feed p_in=6, 20, 42 on consecutive p_valid cycles -> sum_valid=1 one cycle after the 42, sum_out=68, overflow=0, busy=1 until sum_ready.
- Same stream with p_valid low for 2 cycles between each product -> sum_out=68; sum_valid only after the third valid product; count unaffected by gap cycles.
- len=0 start -> next cycle sum_valid=1, sum_out=0; hold sum_ready=0 for 5 cycles -> sum_out stable; sum_ready=1 -> IDLE next cycle.
- ACC_WIDTH=33 build, len=3, p_in=32'hFFFFFFFF x3 -> sum_out=33'h1FFFFFFFF, overflow=1.
- During ACCUM after 2 of 4 products, drive rst_n=0 for one cycle -> all outputs 0 next edge. New start len=1, p_in=9 -> sum_out=9 with no residue from the aborted run.
- Extra p_valid pulses in IDLE/HOLD and a start pulse during ACCUM -> ignored; result equals the sum of the in-window products only.
